// File: rtl/serial_sub16.sv
// Bit-serial subtractor: computes a - b - bin one bit per clock, LSB first,
// and presents diff/bout/zero/ovf with a one-cycle done pulse.
module serial_sub16 #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             zero,
    output logic             ovf
);

    localparam int unsigned CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_nx;
    logic [WIDTH-1:0] a_sh, b_sh, diff_r;
    logic             a_sign, b_sign;
    logic             br, bout_r;
    logic [CW-1:0]    cnt;
    logic             accept, last, d_bit, br_nx;

    assign accept = start && (state != RUN);
    assign last   = (cnt == CW'(WIDTH - 1));
    assign d_bit  = a_sh[0] ^ b_sh[0] ^ br;
    assign br_nx  = (~a_sh[0] & b_sh[0]) | (~(a_sh[0] ^ b_sh[0]) & br);

    always_comb begin
        state_nx = state;
        busy     = 1'b0;
        done     = 1'b0;
        case (state)
            IDLE: if (start) state_nx = RUN;
            RUN: begin
                busy = 1'b1;
                if (last) state_nx = DONE;
            end
            DONE: begin
                done     = 1'b1;
                state_nx = start ? RUN : IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // Operands are shifted right so bit 0 is always the current bit; the
    // sign bits are kept separately for the overflow flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh   <= '0;
            b_sh   <= '0;
            a_sign <= 1'b0;
            b_sign <= 1'b0;
            br     <= 1'b0;
            cnt    <= '0;
            diff_r <= '0;
            bout_r <= 1'b0;
        end else if (accept) begin
            a_sh   <= a;
            b_sh   <= b;
            a_sign <= a[WIDTH-1];
            b_sign <= b[WIDTH-1];
            br     <= bin;
            cnt    <= '0;
        end else if (state == RUN) begin
            a_sh   <= a_sh >> 1;
            b_sh   <= b_sh >> 1;
            diff_r <= {d_bit, diff_r[WIDTH-1:1]};
            br     <= br_nx;
            cnt    <= cnt + 1'b1;
            if (last) bout_r <= br_nx;
        end
    end

    assign diff = diff_r;
    assign bout = bout_r;
    assign zero = (diff_r == '0);
    assign ovf  = (a_sign ^ b_sign) & (diff_r[WIDTH-1] ^ a_sign);

endmodule

// File: tb/tb_serial_sub16.sv
// Directed bench for serial_sub16 (WIDTH=16): latency, results, flags,
// back-to-back operation and asynchronous reset mid-operation.
module tb_serial_sub16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] a = '0;
    logic [15:0] b = '0;
    logic        bin = 1'b0;
    logic        busy, done, bout, zero, ovf;
    logic [15:0] diff;

    int vectors = 0;
    int miscompares = 0;

    serial_sub16 #(.WIDTH(16)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .start(start),
        .a    (a),
        .b    (b),
        .bin  (bin),
        .busy (busy),
        .done (done),
        .diff (diff),
        .bout (bout),
        .zero (zero),
        .ovf  (ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        assert (got === exp)
        else begin
            miscompares++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Called on the negedge just after the accept edge; scrambles operands
    // every cycle and returns the negedge index where done was seen.
    task automatic wait_done(output int cyc, output int nbusy);
        cyc   = 0;
        nbusy = 0;
        do begin
            if (cyc > 0) @(negedge clk);
            cyc++;
            if (busy) nbusy++;
            a   = 16'($urandom);
            b   = 16'($urandom);
            bin = 1'($urandom);
        end while (!done && cyc < 40);
    endtask

    task automatic check_result(input string tag, input logic [15:0] ediff,
                                input logic eb, input logic ez, input logic eo);
        check({tag, "_diff"}, {16'h0, diff}, {16'h0, ediff});
        check({tag, "_flags"}, {29'h0, bout, zero, ovf}, {29'h0, eb, ez, eo});
    endtask

    task automatic run_op(input string tag, input logic [15:0] ta, input logic [15:0] tb_,
                          input logic tbin, input logic [15:0] ediff,
                          input logic eb, input logic ez, input logic eo);
        int cyc, nbusy;
        a = ta; b = tb_; bin = tbin; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        wait_done(cyc, nbusy);
        check({tag, "_latency"}, cyc, 17);
        check({tag, "_busy_cycles"}, nbusy, 16);
        check_result(tag, ediff, eb, ez, eo);
        @(negedge clk);
        check({tag, "_done_pulse"}, {30'h0, busy, done}, 32'h0);
    endtask

    initial begin
        int cyc, nbusy, dones;

        #1;
        check("reset_flags", {27'h0, busy, done, bout, zero, ovf}, 32'b00010);
        check("reset_diff", {16'h0, diff}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        run_op("sub_1234", 16'h1234, 16'h0234, 1'b0, 16'h1000, 1'b0, 1'b0, 1'b0);
        run_op("sub_0m1",  16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0, 1'b0);
        run_op("sub_8000", 16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b0, 1'b1);
        run_op("sub_zero", 16'h0005, 16'h0004, 1'b1, 16'h0000, 1'b0, 1'b1, 1'b0);
        run_op("sub_ffff", 16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0, 1'b0);
        run_op("sub_7fff", 16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b1, 1'b0, 1'b1);

        // start held high: each result must come from its own accept cycle
        a = 16'h0100; b = 16'h0001; bin = 1'b0; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        wait_done(cyc, nbusy);
        check("b2b_first_latency", cyc, 17);
        check_result("b2b_first", 16'h00FF, 1'b0, 1'b0, 1'b0);
        a = 16'h0050; b = 16'h0010; bin = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("b2b_busy_after_done", {30'h0, busy, done}, 32'b10);
        wait_done(cyc, nbusy);
        check("b2b_second_latency", cyc, 17);
        check("b2b_second_busy", nbusy, 16);
        check_result("b2b_second", 16'h003F, 1'b0, 1'b0, 1'b0);
        start = 1'b0;
        @(negedge clk);
        check("b2b_idle", {30'h0, busy, done}, 32'h0);

        // asynchronous reset in the middle of an operation
        a = 16'h00FF; b = 16'h0001; bin = 1'b0; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (7) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrun_reset_flags", {27'h0, busy, done, bout, zero, ovf}, 32'b00010);
        check("midrun_reset_diff", {16'h0, diff}, 32'h0);
        dones = 0;
        repeat (3) begin
            @(negedge clk);
            if (done) dones++;
        end
        check("midrun_reset_no_done", dones, 0);
        rst_n = 1'b1;
        run_op("post_reset", 16'h00FF, 16'h000F, 1'b0, 16'h00F0, 1'b0, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
